// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer for the Tomasulo core.
// Allocates on issue, captures CDB results, commits to the regfile, flushes on a mispredicted branch.
`default_nettype none

package rob_pkg;
    localparam int CDB_DATA_WIDTH = 16;
    localparam int CDB_TAG_WIDTH  = 3;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_SHF = 4'b1101;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef struct packed {
        logic                      valid;
        logic [CDB_TAG_WIDTH-1:0]  tag;
        logic [CDB_DATA_WIDTH-1:0] data;
    } cdb_t;
endpackage

module reorder_buffer #(
    parameter int DATA_WIDTH = rob_pkg::CDB_DATA_WIDTH,
    parameter int TAG_WIDTH  = rob_pkg::CDB_TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rob_write_enable,
    input  logic [3:0]            rob_opcode,
    input  logic [2:0]            rob_dest,
    input  logic [DATA_WIDTH-1:0] rob_value_in,
    output logic [TAG_WIDTH-1:0]  rob_addr,
    output logic                  rob_full,
    input  logic [TAG_WIDTH-1:0]  rob_sr1_read_addr,
    input  logic [TAG_WIDTH-1:0]  rob_sr2_read_addr,
    output logic [DATA_WIDTH-1:0] rob_sr1_value_out,
    output logic [DATA_WIDTH-1:0] rob_sr2_value_out,
    output logic                  rob_sr1_valid_out,
    output logic                  rob_sr2_valid_out,
    input  rob_pkg::cdb_t         CDB_in,
    output logic                  regfile_ld,
    output logic [2:0]            regfile_dest,
    output logic [DATA_WIDTH-1:0] regfile_data,
    output logic [TAG_WIDTH-1:0]  regfile_rob_entry,
    output logic                  flush,
    output logic [DATA_WIDTH-1:0] flush_pc
);
    import rob_pkg::*;

    localparam int DEPTH = 2 ** TAG_WIDTH;
    localparam logic [TAG_WIDTH:0] FULL_COUNT = (TAG_WIDTH + 1)'(DEPTH);

    logic [DEPTH-1:0]      valid;
    logic [DEPTH-1:0]      ready;
    logic [DEPTH-1:0]      mispredict;
    logic [3:0]            opcode [DEPTH];
    logic [2:0]            dest   [DEPTH];
    logic [DATA_WIDTH-1:0] value  [DEPTH];

    logic [TAG_WIDTH-1:0]  head;
    logic [TAG_WIDTH-1:0]  tail;
    logic [TAG_WIDTH:0]    count;

    logic                  full;
    logic                  commit;
    logic                  alloc;
    logic                  cdb_hit;
    logic [3:0]            head_op;
    logic                  head_writes_reg;

    assign full    = (count == FULL_COUNT);
    assign head_op = opcode[head];
    assign commit  = valid[head] & ready[head];

    // A flush wipes the machine, so anything arriving in the same cycle is discarded.
    assign alloc   = rob_write_enable & ~full & ~flush;
    assign cdb_hit = CDB_in.valid & valid[CDB_in.tag] & ~flush;

    always_comb begin
        head_writes_reg = 1'b0;
        case (head_op)
            OP_ADD, OP_AND, OP_NOT, OP_SHF, OP_LDR, OP_LEA: head_writes_reg = 1'b1;
            default:                                        head_writes_reg = 1'b0;
        endcase
    end

    assign regfile_ld        = commit & head_writes_reg;
    assign regfile_dest      = dest[head];
    assign regfile_data      = value[head];
    assign regfile_rob_entry = head;
    assign flush             = commit & (head_op == OP_BR) & mispredict[head];
    assign flush_pc          = value[head];

    assign rob_addr          = tail;
    assign rob_full          = full;
    assign rob_sr1_value_out = value[rob_sr1_read_addr];
    assign rob_sr2_value_out = value[rob_sr2_read_addr];
    assign rob_sr1_valid_out = valid[rob_sr1_read_addr] & ready[rob_sr1_read_addr];
    assign rob_sr2_valid_out = valid[rob_sr2_read_addr] & ready[rob_sr2_read_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid      <= '0;
            ready      <= '0;
            mispredict <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
        end else if (flush) begin
            valid      <= '0;
            ready      <= '0;
            mispredict <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
        end else begin
            if (cdb_hit) begin
                ready[CDB_in.tag] <= 1'b1;
                if (opcode[CDB_in.tag] == OP_BR)
                    mispredict[CDB_in.tag] <= CDB_in.data[0];
            end
            if (commit) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            // The tail slot is never the head while not full, so these never collide.
            if (alloc) begin
                valid[tail]      <= 1'b1;
                ready[tail]      <= (rob_opcode == OP_LEA);
                mispredict[tail] <= 1'b0;
                tail             <= tail + 1'b1;
            end
            case ({alloc, commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: it is only observed through valid/ready.
    always_ff @(posedge clk) begin
        if (cdb_hit && (opcode[CDB_in.tag] != OP_BR))
            value[CDB_in.tag] <= CDB_in.data;
        if (alloc) begin
            opcode[tail] <= rob_opcode;
            dest[tail]   <= rob_dest;
            value[tail]  <= rob_value_in;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenario tests for reorder_buffer.
`default_nettype none

module tb_reorder_buffer;
    import rob_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        rob_write_enable;
    logic [3:0]  rob_opcode;
    logic [2:0]  rob_dest;
    logic [15:0] rob_value_in;
    logic [2:0]  rob_addr;
    logic        rob_full;
    logic [2:0]  rob_sr1_read_addr, rob_sr2_read_addr;
    logic [15:0] rob_sr1_value_out, rob_sr2_value_out;
    logic        rob_sr1_valid_out, rob_sr2_valid_out;
    cdb_t        cdb;
    logic        regfile_ld;
    logic [2:0]  regfile_dest;
    logic [15:0] regfile_data;
    logic [2:0]  regfile_rob_entry;
    logic        flush;
    logic [15:0] flush_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reorder_buffer #(.DATA_WIDTH(16), .TAG_WIDTH(3)) dut (
        .clk(clk), .reset(reset),
        .rob_write_enable(rob_write_enable), .rob_opcode(rob_opcode),
        .rob_dest(rob_dest), .rob_value_in(rob_value_in),
        .rob_addr(rob_addr), .rob_full(rob_full),
        .rob_sr1_read_addr(rob_sr1_read_addr), .rob_sr2_read_addr(rob_sr2_read_addr),
        .rob_sr1_value_out(rob_sr1_value_out), .rob_sr2_value_out(rob_sr2_value_out),
        .rob_sr1_valid_out(rob_sr1_valid_out), .rob_sr2_valid_out(rob_sr2_valid_out),
        .CDB_in(cdb),
        .regfile_ld(regfile_ld), .regfile_dest(regfile_dest),
        .regfile_data(regfile_data), .regfile_rob_entry(regfile_rob_entry),
        .flush(flush), .flush_pc(flush_pc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rob_write_enable = 1'b0;
        rob_opcode = OP_ADD;
        rob_dest = 3'd0;
        rob_value_in = 16'h0000;
        cdb = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] d, input logic [15:0] v);
        rob_write_enable = 1'b1;
        rob_opcode = op;
        rob_dest = d;
        rob_value_in = v;
        step();
        rob_write_enable = 1'b0;
    endtask

    task automatic send_cdb(input logic [2:0] tag, input logic [15:0] data);
        cdb.valid = 1'b1;
        cdb.tag = tag;
        cdb.data = data;
        step();
        cdb = '0;
    endtask

    task automatic test_reset();
        do_reset();
        rob_sr1_read_addr = 3'd0;
        rob_sr2_read_addr = 3'd3;
        checks++; if (rob_addr !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", rob_addr); end
        checks++; if (rob_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", rob_full); end
        checks++; if (regfile_ld !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL reset_ld_flush: got %0b/%0b expected 0/0", regfile_ld, flush); end
        checks++; if (rob_sr1_valid_out !== 1'b0) begin errors++; $display("FAIL reset_sr1_valid: got %0b expected 0", rob_sr1_valid_out); end
        // CDB hit on an unallocated slot must not mark it ready
        send_cdb(3'd3, 16'h0099);
        checks++; if (rob_sr2_valid_out !== 1'b0) begin errors++; $display("FAIL cdb_unalloc: got %0b expected 0", rob_sr2_valid_out); end
        // async reset mid-operation with a ready LEA at head
        issue(OP_LEA, 3'd2, 16'h0abc);
        checks++; if (regfile_ld !== 1'b1) begin errors++; $display("FAIL pre_reset_ld: got %0b expected 1", regfile_ld); end
        #2 reset = 1'b1;
        #1;
        checks++; if (regfile_ld !== 1'b0 || rob_addr !== 3'd0) begin errors++; $display("FAIL async_reset: ld=%0b addr=%0d expected 0/0", regfile_ld, rob_addr); end
        #1 reset = 1'b0;
    endtask

    task automatic test_add_commit();
        do_reset();
        rob_sr1_read_addr = 3'd0;
        issue(OP_ADD, 3'd3, 16'h0000);
        checks++; if (rob_addr !== 3'd1) begin errors++; $display("FAIL add_addr: got %0d expected 1", rob_addr); end
        checks++; if (rob_sr1_valid_out !== 1'b0) begin errors++; $display("FAIL add_pending_valid: got %0b expected 0", rob_sr1_valid_out); end
        checks++; if (regfile_ld !== 1'b0) begin errors++; $display("FAIL add_pending_ld: got %0b expected 0", regfile_ld); end
        send_cdb(3'd0, 16'h0042);
        checks++; if (rob_sr1_valid_out !== 1'b1 || rob_sr1_value_out !== 16'h0042) begin errors++; $display("FAIL add_lookup: valid=%0b value=%h expected 1/0042", rob_sr1_valid_out, rob_sr1_value_out); end
        checks++; if (regfile_ld !== 1'b1 || regfile_dest !== 3'd3 || regfile_data !== 16'h0042 || regfile_rob_entry !== 3'd0) begin
            errors++; $display("FAIL add_commit: ld=%0b dest=%0d data=%h entry=%0d expected 1/3/0042/0", regfile_ld, regfile_dest, regfile_data, regfile_rob_entry); end
        step();
        checks++; if (regfile_rob_entry !== 3'd1 || regfile_ld !== 1'b0) begin errors++; $display("FAIL add_head_adv: entry=%0d ld=%0b expected 1/0", regfile_rob_entry, regfile_ld); end
        checks++; if (rob_sr1_valid_out !== 1'b0) begin errors++; $display("FAIL add_retired_valid: got %0b expected 0", rob_sr1_valid_out); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) issue(OP_LDR, 3'(i), 16'h0000);
        checks++; if (rob_full !== 1'b1 || rob_addr !== 3'd0) begin errors++; $display("FAIL full_set: full=%0b addr=%0d expected 1/0", rob_full, rob_addr); end
        issue(OP_LDR, 3'd7, 16'hdead);
        checks++; if (rob_full !== 1'b1 || rob_addr !== 3'd0) begin errors++; $display("FAIL full_ignore: full=%0b addr=%0d expected 1/0", rob_full, rob_addr); end
        send_cdb(3'd0, 16'h1111);
        checks++; if (regfile_ld !== 1'b1 || regfile_dest !== 3'd0 || regfile_data !== 16'h1111) begin errors++; $display("FAIL full_commit: ld=%0b dest=%0d data=%h expected 1/0/1111", regfile_ld, regfile_dest, regfile_data); end
        step();
        checks++; if (rob_full !== 1'b0 || regfile_rob_entry !== 3'd1) begin errors++; $display("FAIL full_clear: full=%0b entry=%0d expected 0/1", rob_full, regfile_rob_entry); end
    endtask

    task automatic test_lea();
        do_reset();
        issue(OP_LEA, 3'd1, 16'h3000);
        checks++; if (regfile_ld !== 1'b1 || regfile_dest !== 3'd1 || regfile_data !== 16'h3000) begin errors++; $display("FAIL lea_commit: ld=%0b dest=%0d data=%h expected 1/1/3000", regfile_ld, regfile_dest, regfile_data); end
        step();
        checks++; if (regfile_ld !== 1'b0 || regfile_rob_entry !== 3'd1) begin errors++; $display("FAIL lea_done: ld=%0b entry=%0d expected 0/1", regfile_ld, regfile_rob_entry); end
    endtask

    task automatic test_out_of_order();
        logic [2:0]  exp_dest [3] = '{3'd1, 3'd2, 3'd3};
        logic [15:0] exp_data [3] = '{16'h0010, 16'h0011, 16'h0022};
        do_reset();
        rob_sr2_read_addr = 3'd2;
        for (int i = 0; i < 3; i++) issue(OP_ADD, 3'(i + 1), 16'h0000);
        send_cdb(3'd2, 16'h0022);
        checks++; if (regfile_ld !== 1'b0 || rob_sr2_valid_out !== 1'b1) begin errors++; $display("FAIL ooo_tag2: ld=%0b valid2=%0b expected 0/1", regfile_ld, rob_sr2_valid_out); end
        send_cdb(3'd1, 16'h0011);
        checks++; if (regfile_ld !== 1'b0) begin errors++; $display("FAIL ooo_tag1: ld=%0b expected 0", regfile_ld); end
        cdb.valid = 1'b1; cdb.tag = 3'd0; cdb.data = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            step();
            cdb = '0;
            checks++; if (regfile_ld !== 1'b1 || regfile_rob_entry !== 3'(i) || regfile_dest !== exp_dest[i] || regfile_data !== exp_data[i]) begin
                errors++; $display("FAIL ooo_commit%0d: ld=%0b entry=%0d dest=%0d data=%h expected 1/%0d/%0d/%h", i, regfile_ld, regfile_rob_entry, regfile_dest, regfile_data, i, exp_dest[i], exp_data[i]); end
        end
        step();
        checks++; if (regfile_ld !== 1'b0 || regfile_rob_entry !== 3'd3) begin errors++; $display("FAIL ooo_empty: ld=%0b entry=%0d expected 0/3", regfile_ld, regfile_rob_entry); end
    endtask

    task automatic test_branch_flush();
        do_reset();
        rob_sr1_read_addr = 3'd1;
        issue(OP_BR, 3'd0, 16'h1234);
        issue(OP_ADD, 3'd5, 16'h0000);
        send_cdb(3'd0, 16'h0001);
        checks++; if (flush !== 1'b1 || flush_pc !== 16'h1234 || regfile_ld !== 1'b0) begin errors++; $display("FAIL br_flush: flush=%0b pc=%h ld=%0b expected 1/1234/0", flush, flush_pc, regfile_ld); end
        // same-cycle issue and CDB are dropped by the flush
        rob_write_enable = 1'b1; rob_opcode = OP_LEA; rob_dest = 3'd4; rob_value_in = 16'h7777;
        cdb.valid = 1'b1; cdb.tag = 3'd1; cdb.data = 16'h5555;
        step();
        idle_inputs();
        checks++; if (rob_addr !== 3'd0 || rob_full !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL br_after: addr=%0d full=%0b flush=%0b expected 0/0/0", rob_addr, rob_full, flush); end
        checks++; if (rob_sr1_valid_out !== 1'b0 || regfile_ld !== 1'b0) begin errors++; $display("FAIL br_cleared: valid1=%0b ld=%0b expected 0/0", rob_sr1_valid_out, regfile_ld); end
        // correctly predicted branch retires silently
        issue(OP_BR, 3'd0, 16'h5555);
        send_cdb(3'd0, 16'h0000);
        checks++; if (flush !== 1'b0 || regfile_ld !== 1'b0 || regfile_rob_entry !== 3'd0) begin errors++; $display("FAIL br_ok: flush=%0b ld=%0b entry=%0d expected 0/0/0", flush, regfile_ld, regfile_rob_entry); end
        step();
        checks++; if (regfile_rob_entry !== 3'd1 || rob_addr !== 3'd1) begin errors++; $display("FAIL br_ok_retire: entry=%0d addr=%0d expected 1/1", regfile_rob_entry, rob_addr); end
    endtask

    task automatic test_full_simul();
        do_reset();
        for (int i = 0; i < 8; i++) issue(OP_ADD, 3'(i), 16'h0000);
        send_cdb(3'd0, 16'h0007);
        checks++; if (regfile_ld !== 1'b1 || rob_full !== 1'b1) begin errors++; $display("FAIL simul_pre: ld=%0b full=%0b expected 1/1", regfile_ld, rob_full); end
        issue(OP_ADD, 3'd6, 16'h0000);
        checks++; if (rob_addr !== 3'd0 || rob_full !== 1'b0 || regfile_rob_entry !== 3'd1) begin errors++; $display("FAIL simul_drop: addr=%0d full=%0b entry=%0d expected 0/0/1", rob_addr, rob_full, regfile_rob_entry); end
        issue(OP_ADD, 3'd6, 16'h0000);
        checks++; if (rob_addr !== 3'd1 || rob_full !== 1'b1) begin errors++; $display("FAIL simul_refill: addr=%0d full=%0b expected 1/1", rob_addr, rob_full); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            issue(OP_LEA, 3'(i % 8), 16'(i));
            checks++; if (regfile_ld !== 1'b1 || regfile_rob_entry !== 3'(i % 8) || regfile_data !== 16'(i) || rob_addr !== 3'((i + 1) % 8)) begin
                errors++; $display("FAIL wrap%0d: ld=%0b entry=%0d data=%h addr=%0d expected 1/%0d/%h/%0d", i, regfile_ld, regfile_rob_entry, regfile_data, rob_addr, i % 8, i, (i + 1) % 8); end
        end
        step();
        checks++; if (regfile_ld !== 1'b0 || regfile_rob_entry !== 3'd4 || rob_addr !== 3'd4) begin errors++; $display("FAIL wrap_end: ld=%0b entry=%0d addr=%0d expected 0/4/4", regfile_ld, regfile_rob_entry, rob_addr); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        rob_sr1_read_addr = 3'd0;
        rob_sr2_read_addr = 3'd0;
        test_reset();
        test_add_commit();
        test_full();
        test_lea();
        test_out_of_order();
        test_branch_flush();
        test_full_simul();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer for the Tomasulo core. It is the receiving end of the issue-control to ROB interface: it allocates entries on issue and supplies operand look-up values and valid bits back to issue control.
- It captures CDB results and retires entries in program order to the regfile.
- On commit of a mispredicted branch it flushes the machine and supplies the redirect PC to fetch.

Parameters:
- data_width, 16, width of entry value and CDB data.
- tag_width, 3, ROB index width; depth = 2**tag_width (8 entries).

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- rob_write_enable  in  1  issue allocates the entry at tail this cycle.
- rob_opcode  in  4  lc3b_opcode of the issued instruction.
- rob_dest  in  3  architectural destination register.
- rob_value_in  in  data_width  initial value (LEA result, or BR alternate PC).
- rob_addr  out  tag_width  current tail index; the tag issue control assigns.
- rob_full  out  1  count == depth.
- rob_sr1_read_addr, rob_sr2_read_addr  in  tag_width  operand look-up indices.
- rob_sr1_value_out, rob_sr2_value_out  out  data_width  entry value at look-up index.
- rob_sr1_valid_out, rob_sr2_valid_out  out  1  entry at index is allocated and ready.
- CDB_in  in  CDB struct  broadcast {valid, tag[tag_width-1:0], data[data_width-1:0]}.
- regfile_ld  out  1  commit writes the register file this cycle.
- regfile_dest  out  3  committed destination register.
- regfile_data  out  data_width  committed value.
- regfile_rob_entry  out  tag_width  head index; regfile clears busy only if its rob_entry matches.
- flush  out  1  committing a mispredicted branch.
- flush_pc  out  data_width  redirect target (the stored alternate PC).

Behaviour:
- Per-entry state: valid, ready, mispredict, opcode, dest, value. Global state: head, tail, count (tag_width+1 bits).
- Reset (asynchronous): all valid/ready/mispredict = 0, head = tail = count = 0. Outputs: rob_addr = 0, rob_full = 0, all look-up valids 0, regfile_ld = 0, flush = 0.

Allocation:
- When rob_write_enable and not full, on posedge: entry[tail] <= {valid 1, opcode, dest, value_in, mispredict 0}; tail increments mod depth.
- ready at allocation = 1 for op_lea; 0 for all other opcodes.
- rob_write_enable while full is ignored: no state change, tail unchanged.

CDB capture:
- When CDB_in.valid and entry[tag].valid, on posedge: ready <= 1.
- For op_br entries, data[0] is latched into mispredict and value is unchanged.
- For all other opcodes, value <= data.
- A CDB hit on an unallocated entry is ignored.

Look-up:
- Purely combinational from stored state; no CDB bypass (issue control checks the CDB itself).
- valid_out = entry.valid & entry.ready. value_out = entry.value regardless of valid.

Commit:
- Combinational from head. commit = entry[head].valid & entry[head].ready.
- regfile_ld = commit & opcode in {add, and, not, shf, ldr, lea}.
- regfile_dest and regfile_data are taken from the head entry. regfile_rob_entry = head.
- On posedge with commit: entry[head].valid <= 0 and head increments mod depth. At most one retire per cycle.
- Branch commit: flush = commit & op_br & mispredict, flush_pc = head value. A correctly predicted br retires silently.

Flush:
- On posedge with flush: all valid/ready/mispredict <= 0, head = tail = count = 0.
- A same-cycle rob_write_enable is dropped, and a same-cycle CDB write is dropped.

Count and simultaneity:
- Allocate only: +1. Commit only: -1. Both in the same cycle: unchanged.
- Allocate while full is blocked even when commit occurs in the same cycle (full is sampled pre-edge).
- A CDB write and a commit hitting the head in the same cycle: the entry retires no earlier than the next cycle.
- Wrap-around: indices roll over from 7 to 0 with no gap; full when count = 8 and head == tail.
- Reset asserted mid-operation: immediate clear of all state; no commit or flush is emitted.

Test Plan:
- Reset, then issue ADD r3 (opcode add) -> rob_addr goes 0 to 1. Look-up index 0 gives valid 0. CDB {1,0,16'h0042} -> next cycle valid 1, value 16'h0042, regfile_ld = 1 with dest 3, data 0x0042, rob_entry 0; head becomes 1.
- Issue 8 LDRs with no CDB -> rob_full = 1. A 9th write_enable leaves tail at 0. A CDB to tag 0 retires it, count = 7, rob_full deasserts.
- Issue LEA r1 value 0x3000 -> it commits the next cycle with no CDB; regfile_ld with dest 1, data 0x3000.
- Out-of-order completion: issue tags 0, 1, 2; CDB tag 2, then 1, then 0 -> commits occur in order 0, 1, 2 on consecutive cycles.
- BR at tag 0 with value 0x1234, ADD at tag 1; CDB tag 0 data 1 -> flush = 1, flush_pc = 0x1234, regfile_ld = 0. Next cycle count = 0, rob_addr = 0, tag 1 valid = 0.
- Simultaneous issue and commit at count 8 -> write dropped, count 7. Wrap test: 20 issue/commit pairs, tail and head stay in lock-step mod 8.
